// File: rtl/mul64_arbiter_pkg.sv
// Shared definitions for the MUL64 arbiter: FSM state encoding and parameter defaults.
package mul64_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int NREQ_DEFAULT = 4;
    localparam int W_DEFAULT    = 64;

endpackage

// File: rtl/mul64_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after last_grant+1, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    // Scan from the farthest candidate to the nearest so the nearest set request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int off = NREQ; off >= 1; off--) begin
            if (req[(int'(last_grant) + off) % NREQ]) begin
                grant     = NREQ'(1) << ((int'(last_grant) + off) % NREQ);
                grant_idx = IW'((int'(last_grant) + off) % NREQ);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul64_arbiter.sv
// Shares one multi-cycle MUL64 among NREQ requesters; one operation in flight, round-robin grant.
module mul64_arbiter
    import mul64_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int W    = W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [2*W-1:0]      rsp_data,
    output logic                busy,
    output logic                mul_enable,
    output logic [W-1:0]        mul1,
    output logic [W-1:0]        mul2,
    input  logic [2*W-1:0]      mul_result,
    input  logic                mul_valid
);

    localparam int IW = $clog2(NREQ);

    state_t          state_reg;
    state_t          state_next;
    logic [W-1:0]    op_a_reg;
    logic [W-1:0]    op_b_reg;
    logic [2*W-1:0]  prod_reg;
    logic [IW-1:0]   gid_reg;
    logic [IW-1:0]   last_grant_reg;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .grant      (pick_grant),
        .grant_idx  (pick_idx),
        .any        (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // req_ready is gated by rst_n so a held request sees no acceptance while reset is asserted.
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_data   = '0;
        mul_enable = 1'b0;
        mul1       = '0;
        mul2       = '0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (pick_any && rst_n) begin
                    req_ready  = pick_grant;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mul_enable = 1'b1;
                mul1       = op_a_reg;
                mul2       = op_b_reg;
                state_next = WAIT;
            end
            WAIT: begin
                mul1 = op_a_reg;
                mul2 = op_b_reg;
                if (mul_valid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                mul1       = op_a_reg;
                mul2       = op_b_reg;
                rsp_valid  = NREQ'(1) << gid_reg;
                rsp_data   = prod_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // mul_valid is only honoured in WAIT, so a level left high from the previous product is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            prod_reg       <= '0;
            gid_reg        <= '0;
            last_grant_reg <= IW'(NREQ - 1);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        op_a_reg <= req_a[pick_idx * W +: W];
                        op_b_reg <= req_b[pick_idx * W +: W];
                        gid_reg  <= pick_idx;
                    end
                end
                WAIT: begin
                    if (mul_valid) begin
                        prod_reg <= mul_result;
                    end
                end
                RESP: begin
                    last_grant_reg <= gid_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul64_arbiter.sv
// Self-checking bench for mul64_arbiter with an L=4 MUL64 model and a queue-based requester/scoreboard model.
`timescale 1ns/1ps
module tb_mul64_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 64;
    localparam int L    = 4;
    localparam int QD   = 64;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] exp;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [2*W-1:0]      rsp_data;
    logic                busy;
    logic                mul_enable;
    logic [W-1:0]        mul1;
    logic [W-1:0]        mul2;
    logic [2*W-1:0]      mul_result;
    logic                mul_valid;

    mul64_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .mul_enable (mul_enable),
        .mul1       (mul1),
        .mul2       (mul2),
        .mul_result (mul_result),
        .mul_valid  (mul_valid)
    );

    always #5 clk = ~clk;

    // MUL64 model: mul_valid pulses L cycles after mul_enable; stale_force can hold it high.
    logic [L-1:0]   mpipe = '0;
    logic [2*W-1:0] mprod = '0;
    logic           stale_force = 1'b0;
    always @(posedge clk) begin
        mpipe <= {mpipe[L-2:0], mul_enable};
        if (mul_enable) mprod <= {{W{1'b0}}, mul1} * {{W{1'b0}}, mul2};
    end
    assign mul_valid  = mpipe[L-1] | stale_force;
    assign mul_result = mprod;

    // Requester model: per-requester FIFO of pending operations.
    op_t pend[NREQ][QD];
    int  head[NREQ];
    int  tail[NREQ];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit             inflight = 1'b0;
    int             lg_model = NREQ - 1;
    int             cur_id   = 0;
    int             acc_cyc  = 0;
    op_t            cur_op;
    logic [2*W-1:0] cur_exp;

    int             acc_n = 0;
    int             rsp_n = 0;
    int             log_acc_id[256];
    int             log_acc_cyc[256];
    int             log_rsp_id[256];
    logic [2*W-1:0] log_rsp_data[256];

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int predict(input logic [NREQ-1:0] rv, input int lg);
        for (int off = 1; off <= NREQ; off++)
            if (rv[(lg + off) % NREQ]) return (lg + off) % NREQ;
        return -1;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit pending_any();
        for (int i = 0; i < NREQ; i++)
            if (head[i] != tail[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Input driver: presents the head of each queue just after every rising edge.
    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (head[i] != tail[i]) begin
                    req_valid[i]       = 1'b1;
                    req_a[i*W +: W]    = pend[i][head[i]].a;
                    req_b[i*W +: W]    = pend[i][head[i]].b;
                end else begin
                    req_valid[i]       = 1'b0;
                    req_a[i*W +: W]    = '0;
                    req_b[i*W +: W]    = '0;
                end
            end
        end
    end

    // Monitor/scoreboard: samples on the falling edge and compares against the model.
    initial begin
        int             win;
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_rsp;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                check("rst_ready", req_ready, 0);
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_rsp_data", rsp_data, 0);
                check("rst_mul_ops", {mul1, mul2}, 0);
                check("rst_busy_en", {busy, mul_enable}, 0);
                inflight = 1'b0;
                lg_model = NREQ - 1;
            end else begin
                check("busy", busy, inflight);
                if (!inflight) check("mul_ops_idle", {mul1, mul2}, 0);
                win       = inflight ? -1 : predict(req_valid, lg_model);
                exp_ready = (win >= 0) ? NREQ'(1) << win : '0;
                check("req_ready", req_ready, exp_ready);
                if (win >= 0) begin
                    cur_op   = pend[win][head[win]];
                    head[win]++;
                    cur_id   = win;
                    cur_exp  = {{W{1'b0}}, cur_op.a} * {{W{1'b0}}, cur_op.b};
                    acc_cyc  = cyc;
                    inflight = 1'b1;
                    log_acc_id[acc_n]  = idx_of(req_ready);
                    log_acc_cyc[acc_n] = cyc;
                    acc_n++;
                end
                check("mul_enable", mul_enable, inflight && (cyc == acc_cyc + 1));
                if (inflight && cyc >= acc_cyc + 1 && cyc <= acc_cyc + 1 + L)
                    check("mul_operands", {mul1, mul2}, {cur_op.a, cur_op.b});
                exp_rsp = (inflight && cyc == acc_cyc + 2 + L) ? NREQ'(1) << cur_id : '0;
                check("rsp_valid", rsp_valid, exp_rsp);
                if (exp_rsp != 0) begin
                    check("rsp_data", rsp_data, cur_exp);
                    log_rsp_id[rsp_n]   = idx_of(rsp_valid);
                    log_rsp_data[rsp_n] = rsp_data;
                    rsp_n++;
                    lg_model = cur_id;
                    inflight = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((inflight || pending_any()) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (inflight || pending_any()) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
        end
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    task automatic push(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        if (tail[id] >= QD) wait_idle(5000);
        pend[id][tail[id]].a = a;
        pend[id][tail[id]].b = b;
        tail[id]++;
    endtask

    task automatic wait_enable(input int budget);
        int n = 0;
        while (!mul_enable && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!mul_enable) begin
            errors++;
            $display("FAIL wait_enable: mul_enable got 0 expected 1 within %0d cycles", budget);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   a0;
        int   r0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-operation vectors, each checked against a constant product and id.
        vecs[0] = '{0, 64'd3, 64'd5, 128'd15};
        vecs[1] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vecs[2] = '{1, 64'd0, 64'hDEAD_BEEF_0000_1234, 128'd0};
        vecs[3] = '{3, 64'h8000_0000_0000_0000, 64'd2, 128'h1_0000_0000_0000_0000};
        vecs[4] = '{0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 128'hFFFF_FFFE_0000_0001};
        for (int v = 0; v < 5; v++) begin
            r0 = rsp_n;
            push(vecs[v].id, vecs[v].a, vecs[v].b);
            wait_idle(50);
            check("vec_count", rsp_n - r0, 1);
            check("vec_id", log_rsp_id[r0], vecs[v].id);
            check("vec_data", log_rsp_data[r0], vecs[v].exp);
        end

        // All four requesting right after reset: grants 0..3, seven cycles apart.
        do_reset(3);
        tick();
        a0 = acc_n;
        r0 = rsp_n;
        for (int i = 0; i < NREQ; i++) push(i, 64'(i + 1), 64'd2);
        wait_idle(100);
        for (int i = 0; i < NREQ; i++) begin
            check("all4_grant_order", log_acc_id[a0 + i], i);
            check("all4_data", log_rsp_data[r0 + i], 128'(2 * (i + 1)));
            if (i > 0) check("all4_spacing", log_acc_cyc[a0 + i] - log_acc_cyc[a0 + i - 1], 7);
        end

        // Fairness: after a grant to 2, pending 1 and 3 resolve as 3 then 1.
        a0 = acc_n;
        push(2, 64'd11, 64'd13);
        wait_enable(20);
        push(1, 64'd17, 64'd19);
        push(3, 64'd23, 64'd29);
        wait_idle(100);
        check("fair_first", log_acc_id[a0], 2);
        check("fair_second", log_acc_id[a0 + 1], 3);
        check("fair_third", log_acc_id[a0 + 2], 1);

        // Stale mul_valid held high through IDLE and ISSUE must not cut the operation short.
        r0 = rsp_n;
        @(posedge clk);
        #1;
        stale_force = 1'b1;
        push(0, 64'h1234_5678_9ABC_DEF0, 64'h10);
        wait_enable(20);
        @(posedge clk);
        #1;
        stale_force = 1'b0;
        wait_idle(50);
        check("stale_count", rsp_n - r0, 1);
        check("stale_data", log_rsp_data[r0], 128'h1_2345_6789_ABCD_EF00);

        // Reset asserted in WAIT: outputs clear at once, no response, pending req 1 regranted afterwards.
        r0 = rsp_n;
        push(1, 64'd7, 64'd9);
        wait_enable(20);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_mul", {mul1, mul2}, 0);
        push(1, 64'd7, 64'd9);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b1;
        a0 = acc_n;
        wait_idle(50);
        check("rst_rsp_count", rsp_n - r0, 1);
        check("rst_regrant_id", log_acc_id[a0], 1);
        check("rst_regrant_data", log_rsp_data[r0], 128'd63);

        // Randomized traffic checked continuously by the monitor.
        r0 = rsp_n;
        for (int k = 0; k < 60; k++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (k % 7 == 0) ra = '1;
            push(int'($urandom_range(0, NREQ - 1)), ra, rb);
            repeat ($urandom_range(0, 8)) tick();
        end
        wait_idle(2000);
        check("rand_count", rsp_n - r0, 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
